stack_controller: RTL and testbench

STACK_CONTROLLER -- requirements
Module: stack_controller

---
 rtl/stack_pkg.sv | 34 +++
 rtl/stack_controller.sv | 171 +++++++++++++++++
 tb/tb_stack_controller.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared opcodes, FSM states and operand-count helpers for the stack controller
package stack_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_DROP    = 3'd2,
        OP_DUP     = 3'd3,
        OP_SWAP    = 3'd4,
        OP_OVER    = 3'd5,
        OP_BINOP   = 3'd6,
        OP_REPLACE = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWAP2 = 1'b1
    } state_e;

    // Minimum number of entries an opcode must find on the stack.
    function automatic logic [1:0] min_count(input op_e op);
        case (op)
            OP_DROP, OP_DUP, OP_REPLACE: min_count = 2'd1;
            OP_SWAP, OP_OVER, OP_BINOP:  min_count = 2'd2;
            default:                     min_count = 2'd0;
        endcase
    endfunction

    // Opcodes that grow the stack by one and so need a free slot.
    function automatic logic needs_room(input op_e op);
        needs_room = (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/stack_controller.sv
// rtl/stack_controller.sv - stack pointer, SWAP sequencer and registered memory write port
//
// Ports:
//   c_CLOCK, c_NRESET          clock, async active-low reset
//   i_VALID, i_OP, i_DATA      command and its immediate operand
//   i_OP1, i_OP2               top and second stack values read from memory
//   i_CLEAR                    clears sticky error flags
//   o_READY                    command accepted when i_VALID is high
//   o_RADDR                    top-of-stack address (BASE+count-1)
//   o_WADDR, o_DATA, o_WRITE   registered one-cycle memory write
//   o_COUNT, o_EMPTY, o_FULL   occupancy
//   o_OVERFLOW, o_UNDERFLOW    sticky error flags
module stack_controller
    import stack_pkg::*;
#(
    parameter int          DEPTH = 64,
    parameter logic [15:0] BASE  = 16'h0000
) (
    input  logic        c_CLOCK,
    input  logic        c_NRESET,
    input  logic        i_VALID,
    input  logic [2:0]  i_OP,
    input  logic [15:0] i_DATA,
    input  logic [15:0] i_OP1,
    input  logic [15:0] i_OP2,
    input  logic        i_CLEAR,
    output logic        o_READY,
    output logic [15:0] o_RADDR,
    output logic [15:0] o_WADDR,
    output logic [15:0] o_DATA,
    output logic        o_WRITE,
    output logic [6:0]  o_COUNT,
    output logic        o_EMPTY,
    output logic        o_FULL,
    output logic        o_OVERFLOW,
    output logic        o_UNDERFLOW
);

    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    state_e      state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic        write_q, write_d;
    logic [15:0] waddr_q, waddr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic [15:0] swap_data_q, swap_data_d;
    logic [15:0] swap_addr_q, swap_addr_d;

    op_e         op;
    logic [15:0] top_addr;
    logic        lo_bad;
    logic        hi_bad;

    assign op       = op_e'(i_OP);
    // Address of the next free cell; other targets are offsets from it.
    assign top_addr = BASE + {9'd0, count_q};
    assign lo_bad   = count_q < {5'd0, min_count(op)};
    assign hi_bad   = needs_room(op) && (count_q == DEPTH_C);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        write_d     = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        swap_data_d = swap_data_q;
        swap_addr_d = swap_addr_q;
        ovf_d       = i_CLEAR ? 1'b0 : ovf_q;
        unf_d       = i_CLEAR ? 1'b0 : unf_q;

        case (state_q)
            ST_IDLE: begin
                if (i_VALID) begin
                    // Lower-bound violations win: an empty DUP is underflow.
                    if (lo_bad) begin
                        unf_d = 1'b1;
                    end else if (hi_bad) begin
                        ovf_d = 1'b1;
                    end else begin
                        case (op)
                            OP_PUSH: begin
                                write_d = 1'b1;
                                waddr_d = top_addr;
                                wdata_d = i_DATA;
                                count_d = count_q + 7'd1;
                            end
                            OP_DROP: count_d = count_q - 7'd1;
                            OP_DUP: begin
                                write_d = 1'b1;
                                waddr_d = top_addr;
                                wdata_d = i_OP1;
                                count_d = count_q + 7'd1;
                            end
                            OP_OVER: begin
                                write_d = 1'b1;
                                waddr_d = top_addr;
                                wdata_d = i_OP2;
                                count_d = count_q + 7'd1;
                            end
                            OP_BINOP: begin
                                write_d = 1'b1;
                                waddr_d = top_addr - 16'd2;
                                wdata_d = i_DATA;
                                count_d = count_q - 7'd1;
                            end
                            OP_REPLACE: begin
                                write_d = 1'b1;
                                waddr_d = top_addr - 16'd1;
                                wdata_d = i_DATA;
                            end
                            OP_SWAP: begin
                                write_d     = 1'b1;
                                waddr_d     = top_addr - 16'd1;
                                wdata_d     = i_OP2;
                                swap_data_d = i_OP1;
                                swap_addr_d = top_addr - 16'd2;
                                state_d     = ST_SWAP2;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_SWAP2: begin
                write_d = 1'b1;
                waddr_d = swap_addr_q;
                wdata_d = swap_data_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge c_CLOCK or negedge c_NRESET) begin
        if (!c_NRESET) begin
            state_q     <= ST_IDLE;
            count_q     <= 7'd0;
            write_q     <= 1'b0;
            waddr_q     <= 16'd0;
            wdata_q     <= 16'd0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            swap_data_q <= 16'd0;
            swap_addr_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            write_q     <= write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            swap_data_q <= swap_data_d;
            swap_addr_q <= swap_addr_d;
        end
    end

    assign o_READY     = (state_q == ST_IDLE);
    assign o_RADDR     = top_addr - 16'd1;
    assign o_WADDR     = waddr_q;
    assign o_DATA      = wdata_q;
    assign o_WRITE     = write_q;
    assign o_COUNT     = count_q;
    assign o_EMPTY     = (count_q == 7'd0);
    assign o_FULL      = (count_q == DEPTH_C);
    assign o_OVERFLOW  = ovf_q;
    assign o_UNDERFLOW = unf_q;

endmodule

// File: tb/tb_stack_controller.sv
// tb/tb_stack_controller.sv - scoreboard bench for stack_controller
module tb_stack_controller;

    localparam int          DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic [2:0]  i_op = 3'd0;
    logic [15:0] i_data = 16'd0;
    logic [15:0] i_op1 = 16'd0;
    logic [15:0] i_op2 = 16'd0;
    logic        i_clear = 1'b0;
    logic        o_ready;
    logic [15:0] o_raddr, o_waddr, o_data;
    logic        o_write;
    logic [6:0]  o_count;
    logic        o_empty, o_full, o_ovf, o_unf;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    stack_controller #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .c_CLOCK(clk), .c_NRESET(rst_n), .i_VALID(i_valid), .i_OP(i_op),
        .i_DATA(i_data), .i_OP1(i_op1), .i_OP2(i_op2), .i_CLEAR(i_clear),
        .o_READY(o_ready), .o_RADDR(o_raddr), .o_WADDR(o_waddr), .o_DATA(o_data),
        .o_WRITE(o_write), .o_COUNT(o_count), .o_EMPTY(o_empty), .o_FULL(o_full),
        .o_OVERFLOW(o_ovf), .o_UNDERFLOW(o_unf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every write pulse is compared against the oldest expected write.
    always @(negedge clk) begin
        if (o_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", o_waddr, o_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if ({o_waddr, o_data} !== e) begin
                    errors++;
                    $display("FAIL write: got addr %h data %h expected addr %h data %h",
                             o_waddr, o_data, e[31:16], e[15:0]);
                end
            end
        end
    end

    // Issue one command in the IDLE cycle; returns at the negedge after acceptance.
    task automatic cmd(input logic [2:0] op, input logic [15:0] d,
                       input logic [15:0] a, input logic [15:0] b);
        i_valid = 1'b1; i_op = op; i_data = d; i_op1 = a; i_op2 = b;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0; i_op = 3'd0;
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #12;
        check("rst_count", {25'd0, o_count}, 32'd0);
        check("rst_empty", {31'd0, o_empty}, 32'd1);
        check("rst_full", {31'd0, o_full}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_raddr", {16'd0, o_raddr}, 32'h00FF);
        check("rst_flags", {30'd0, o_ovf, o_unf}, 32'd0);
        check("rst_write", {31'd0, o_write}, 32'd0);
        check("rst_wport", {o_waddr, o_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Underflow on empty DROP, then clear
        cmd(3'd2, 16'h0, 16'h0, 16'h0);
        check("drop_empty_unf", {31'd0, o_unf}, 32'd1);
        check("drop_empty_count", {25'd0, o_count}, 32'd0);
        i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
        check("clear_unf", {31'd0, o_unf}, 32'd0);

        expect_write(16'h0100, 16'h1111);
        cmd(3'd1, 16'h1111, 16'h0, 16'h0);
        expect_write(16'h0101, 16'h2222);
        cmd(3'd1, 16'h2222, 16'h0, 16'h0);
        check("push2_count", {25'd0, o_count}, 32'd2);
        check("push2_raddr", {16'd0, o_raddr}, 32'h0101);

        expect_write(16'h0101, 16'h1111);
        expect_write(16'h0100, 16'h2222);
        cmd(3'd4, 16'h0, 16'h2222, 16'h1111);
        check("swap_ready_low", {31'd0, o_ready}, 32'd0);
        @(negedge clk);
        check("swap_ready_back", {31'd0, o_ready}, 32'd1);
        check("swap_count", {25'd0, o_count}, 32'd2);

        expect_write(16'h0100, 16'h3333);
        cmd(3'd6, 16'h3333, 16'h0, 16'h0);
        check("binop_count", {25'd0, o_count}, 32'd1);

        expect_write(16'h0100, 16'h4444);
        cmd(3'd7, 16'h4444, 16'h0, 16'h0);
        check("replace_count", {25'd0, o_count}, 32'd1);

        expect_write(16'h0101, 16'h4444);
        cmd(3'd3, 16'h0, 16'h4444, 16'h0);
        expect_write(16'h0102, 16'h5555);
        cmd(3'd5, 16'h0, 16'h4444, 16'h5555);
        check("over_count", {25'd0, o_count}, 32'd3);
        cmd(3'd0, 16'h9999, 16'h0, 16'h0);
        check("nop_count", {25'd0, o_count}, 32'd3);

        expect_write(16'h0103, 16'h6666);
        cmd(3'd1, 16'h6666, 16'h0, 16'h0);
        check("full_flag", {31'd0, o_full}, 32'd1);
        cmd(3'd1, 16'h7777, 16'h0, 16'h0);
        check("ovf_flag", {31'd0, o_ovf}, 32'd1);
        check("ovf_count", {25'd0, o_count}, 32'd4);
        check("ovf_full", {31'd0, o_full}, 32'd1);
        check("ovf_no_unf", {31'd0, o_unf}, 32'd0);

        // Error in the same cycle as clear keeps the flag set
        i_clear = 1'b1;
        cmd(3'd1, 16'h8888, 16'h0, 16'h0);
        i_clear = 1'b0;
        check("clear_vs_error", {31'd0, o_ovf}, 32'd1);
        i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;
        check("clear_ovf", {31'd0, o_ovf}, 32'd0);

        cmd(3'd2, 16'h0, 16'h0, 16'h0);
        cmd(3'd2, 16'h0, 16'h0, 16'h0);
        cmd(3'd2, 16'h0, 16'h0, 16'h0);
        check("drop3_count", {25'd0, o_count}, 32'd1);
        cmd(3'd5, 16'h0, 16'h0, 16'hDEAD);
        check("over_unf", {31'd0, o_unf}, 32'd1);
        check("over_unf_count", {25'd0, o_count}, 32'd1);
        i_clear = 1'b1; @(negedge clk); i_clear = 1'b0;

        expect_write(16'h0101, 16'hAAAA);
        cmd(3'd1, 16'hAAAA, 16'h0, 16'h0);

        // Reset while in SWAP2: first write seen, second abandoned
        expect_write(16'h0101, 16'hBBBB);
        cmd(3'd4, 16'h0, 16'hAAAA, 16'hBBBB);
        #2 rst_n = 1'b0;
        #1;
        check("rst_swap_count", {25'd0, o_count}, 32'd0);
        check("rst_swap_ready", {31'd0, o_ready}, 32'd1);
        check("rst_swap_write", {31'd0, o_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("pending_writes", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
